// File: rtl/alu_exec_stage_if.sv
// Handshake bundle for the ALU execute stage: decode-side request and writeback-side result.
// The master side produces requests and consumes results; the slave side is the stage itself.
interface alu_exec_stage_if #(
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_aluop;
  logic [31:0]      in_a;
  logic [31:0]      in_b;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_result;
  logic             out_zero;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_aluop, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_zero, out_tag
  );

  modport slave (
    input  in_valid, in_aluop, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_zero, out_tag
  );
endinterface

// File: rtl/alu_exec_stage.sv
// Execute stage: one registered operand stage feeding a combinational 32-bit ALU,
// followed by a 2-entry result FIFO toward writeback, plus a completed-operation counter.

module alu_exec_stage_alu (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  aluop,
  output logic [31:0] result,
  output logic        zero
);
  always_comb begin
    result = 32'd0;
    case (aluop)
      4'b0000: result = a & b;
      4'b0001: result = a | b;
      4'b0010: result = a + b;
      4'b0110: result = a - b;
      4'b0111: result = {31'd0, $signed(a) < $signed(b)};
      4'b1100: result = ~(a | b);
      default: result = 32'd0;
    endcase
  end

  assign zero = (result == 32'd0);
endmodule

module alu_exec_stage #(
  parameter int TAG_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_exec_stage_if.slave    bus,
  output logic [15:0]        op_count
);
  logic             s1_valid_reg;
  logic [3:0]       s1_aluop_reg;
  logic [31:0]      s1_a_reg;
  logic [31:0]      s1_b_reg;
  logic [TAG_W-1:0] s1_tag_reg;

  logic [31:0]      fifo_result_reg [2];
  logic             fifo_zero_reg   [2];
  logic [TAG_W-1:0] fifo_tag_reg    [2];
  logic             wr_ptr_reg;
  logic             rd_ptr_reg;
  logic [1:0]       count_reg;
  logic [1:0]       count_next;
  logic [15:0]      op_count_reg;

  logic [31:0]      alu_result;
  logic             alu_zero;
  logic             pop;
  logic             push;
  logic             fifo_space;
  logic             accept;

  alu_exec_stage_alu u_alu (
    .a      (s1_a_reg),
    .b      (s1_b_reg),
    .aluop  (s1_aluop_reg),
    .result (alu_result),
    .zero   (alu_zero)
  );

  assign pop        = bus.out_valid && bus.out_ready;
  assign fifo_space = (count_reg < 2'd2) || pop;
  assign push       = s1_valid_reg && fifo_space;
  // in_ready reaches back to out_ready through fifo_space so a full pipe can still stream.
  assign bus.in_ready = !s1_valid_reg || push;
  assign accept       = bus.in_valid && bus.in_ready;

  assign bus.out_valid  = (count_reg != 2'd0);
  assign bus.out_result = fifo_result_reg[rd_ptr_reg];
  assign bus.out_zero   = fifo_zero_reg[rd_ptr_reg];
  assign bus.out_tag    = fifo_tag_reg[rd_ptr_reg];
  assign op_count       = op_count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_aluop_reg <= 4'd0;
      s1_a_reg     <= 32'd0;
      s1_b_reg     <= 32'd0;
      s1_tag_reg   <= '0;
    end else begin
      if (accept) begin
        s1_valid_reg <= 1'b1;
        s1_aluop_reg <= bus.in_aluop;
        s1_a_reg     <= bus.in_a;
        s1_b_reg     <= bus.in_b;
        s1_tag_reg   <= bus.in_tag;
      end else if (push) begin
        s1_valid_reg <= 1'b0;
      end
    end
  end

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 2'd1;
      2'b01:   count_next = count_reg - 2'd1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        fifo_result_reg[i] <= 32'd0;
        fifo_zero_reg[i]   <= 1'b0;
        fifo_tag_reg[i]    <= '0;
      end
      wr_ptr_reg   <= 1'b0;
      rd_ptr_reg   <= 1'b0;
      count_reg    <= 2'd0;
      op_count_reg <= 16'd0;
    end else begin
      if (push) begin
        fifo_result_reg[wr_ptr_reg] <= alu_result;
        fifo_zero_reg[wr_ptr_reg]   <= alu_zero;
        fifo_tag_reg[wr_ptr_reg]    <= s1_tag_reg;
        wr_ptr_reg                  <= ~wr_ptr_reg;
      end
      if (pop) begin
        rd_ptr_reg   <= ~rd_ptr_reg;
        op_count_reg <= op_count_reg + 16'd1;
      end
      count_reg <= count_next;
    end
  end
endmodule

// File: tb/tb_alu_exec_stage.sv
// Randomized and directed bench for alu_exec_stage, scored against a queue-based reference.
module tb_alu_exec_stage;
  logic        clk;
  logic        rst_n;
  logic [15:0] op_count;

  alu_exec_stage_if #(.TAG_W(5)) bus ();

  alu_exec_stage #(.TAG_W(5)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .op_count (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] r;
    logic        z;
    logic [4:0]  t;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] exp_cnt;
  int          n_checks;
  int          n_fail;
  logic        acc;

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_result(input logic [3:0] op, input logic [31:0] a,
                                                input logic [31:0] b);
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return 32'(longint'(a) + longint'(b));
      4'd6:    return 32'(longint'(a) - longint'(b));
      4'd7:    return (sa < sb) ? 32'd1 : 32'd0;
      4'd12:   return ~(a | b);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [3:0] rand_op();
    logic [3:0] ops [8];
    ops = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12, 4'd2, 4'd6};
    if ($urandom_range(0, 9) == 0) return 4'($urandom);
    return ops[$urandom_range(0, 7)];
  endfunction

  task automatic randomize_fields();
    bus.in_aluop = rand_op();
    bus.in_a     = ($urandom_range(0, 3) == 0) ? bus.in_b : $urandom;
    bus.in_b     = $urandom;
    bus.in_tag   = 5'($urandom);
  endtask

  // One clock: sample handshakes on the falling edge, return 1 ns after the rising edge.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    acc = bus.in_valid && bus.in_ready;
    if (acc) begin
      e.r = model_result(bus.in_aluop, bus.in_a, bus.in_b);
      e.z = (e.r == 32'd0);
      e.t = bus.in_tag;
      exp_q.push_back(e);
    end
    check_value("op_count", {48'd0, op_count}, {48'd0, exp_cnt});
    if (bus.out_valid) begin
      if (exp_q.size() == 0) begin
        check_value("spurious_out", 64'd1, 64'd0);
      end else begin
        check_value("head_result", {32'd0, bus.out_result}, {32'd0, exp_q[0].r});
        check_value("head_zero", {63'd0, bus.out_zero}, {63'd0, exp_q[0].z});
        check_value("head_tag", {59'd0, bus.out_tag}, {59'd0, exp_q[0].t});
        if (bus.out_ready) begin
          void'(exp_q.pop_front());
          exp_cnt = exp_cnt + 16'd1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] tag, output int waits);
    bus.in_valid = 1'b1;
    bus.in_aluop = op;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_tag   = tag;
    waits = 0;
    cycle();
    while (!acc && waits < 50) begin
      waits++;
      cycle();
    end
    if (!acc) check_value("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    int n;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    n = 0;
    while (exp_q.size() > 0 && n < 20) begin
      cycle();
      n++;
    end
    check_value("drain_empty", 64'(exp_q.size()), 64'd0);
    cycle();
    check_value("drain_idle", {63'd0, bus.out_valid}, 64'd0);
    bus.out_ready = 1'b0;
  endtask

  task automatic single(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input logic [31:0] exp_r, input logic exp_z);
    int w;
    bus.out_ready = 1'b0;
    send(op, a, b, tag, w);
    bus.in_valid = 1'b0;
    randomize_fields();
    check_value("lat_edge1_valid", {63'd0, bus.out_valid}, 64'd0);
    cycle();
    check_value("lat_edge2_valid", {63'd0, bus.out_valid}, 64'd1);
    check_value("single_result", {32'd0, bus.out_result}, {32'd0, exp_r});
    check_value("single_zero", {63'd0, bus.out_zero}, {63'd0, exp_z});
    check_value("single_tag", {59'd0, bus.out_tag}, {59'd0, tag});
    bus.out_ready = 1'b1;
    cycle();
    bus.out_ready = 1'b0;
    check_value("single_popped", {63'd0, bus.out_valid}, 64'd0);
  endtask

  initial begin
    int          w;
    int          n_acc;
    logic [15:0] base;

    n_checks = 0;
    n_fail   = 0;
    exp_cnt  = 16'd0;
    acc      = 1'b0;
    rst_n    = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_aluop  = 4'd0;
    bus.in_a      = 32'd0;
    bus.in_b      = 32'd0;
    bus.in_tag    = 5'd0;

    #3;
    check_value("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check_value("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    check_value("rst_out_result", {32'd0, bus.out_result}, 64'd0);
    check_value("rst_out_zero", {63'd0, bus.out_zero}, 64'd0);
    check_value("rst_out_tag", {59'd0, bus.out_tag}, 64'd0);
    check_value("rst_op_count", {48'd0, op_count}, 64'd0);
    #9 rst_n = 1'b1;
    @(posedge clk);
    #1;

    single(4'b0010, 32'h5, 32'h3, 5'd7, 32'h8, 1'b0);
    check_value("op_count_after_first", {48'd0, op_count}, 64'd1);
    single(4'b0110, 32'h12345678, 32'h12345678, 5'd3, 32'h0, 1'b1);
    single(4'b0010, 32'hFFFFFFFF, 32'h1, 5'd9, 32'h0, 1'b1);

    base = op_count;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(4'b0010, 32'(i), 32'd1, 5'(i), w);
      check_value("stream_no_stall", 64'(w), 64'd0);
    end
    drain();
    check_value("stream_op_count", {48'd0, op_count - base}, 64'd8);

    for (int i = 0; i < 400; i++) begin
      bus.in_valid  = 1'($urandom);
      bus.out_ready = 1'($urandom);
      randomize_fields();
      cycle();
    end
    drain();

    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    randomize_fields();
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (acc) begin
        n_acc++;
        randomize_fields();
      end
    end
    check_value("bp_accepts", 64'(n_acc), 64'd3);
    check_value("bp_in_ready_low", {63'd0, bus.in_ready}, 64'd0);
    bus.out_ready = 1'b1;
    #1;
    check_value("bp_pop_in_ready", {63'd0, bus.in_ready}, 64'd1);
    cycle();
    check_value("bp_pop_accept", {63'd0, acc}, 64'd1);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    randomize_fields();
    #1;
    check_value("bp_full_again", {63'd0, bus.in_ready}, 64'd0);
    check_value("bp_head_valid", {63'd0, bus.out_valid}, 64'd1);

    rst_n = 1'b0;
    #1;
    check_value("midrst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check_value("midrst_op_count", {48'd0, op_count}, 64'd0);
    check_value("midrst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    check_value("midrst_out_result", {32'd0, bus.out_result}, 64'd0);
    rst_n = 1'b1;
    exp_q.delete();
    exp_cnt = 16'd0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) cycle();

    for (int i = 0; i < 65536; i++) begin
      send(rand_op(), $urandom, $urandom, 5'($urandom), w);
    end
    drain();
    check_value("wrap_op_count", {48'd0, op_count}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
